// File: rtl/prbs_pkg.sv
// Shared definitions for the 4-bit PRBS generator/checker pair: checker state
// encoding, default polynomial and lock/loss thresholds.
package prbs_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // x^4 + x^3 + 1: next bit = sr[3] ^ sr[2]
    localparam int                PRBS_N    = 4;
    localparam logic [PRBS_N-1:0] PRBS_TAPS = 4'b1100;

    localparam int PRBS_LOCK_CNT = 8;
    localparam int PRBS_WIN      = 16;
    localparam int PRBS_LOSS_ERR = 4;
    localparam int PRBS_ERR_W    = 16;

endpackage

// File: rtl/prbs_chk_lfsr.sv
// Local shift register of the PRBS checker: loads received bits while hunting
// and free-runs on its own prediction once locked.
module prbs_chk_lfsr
    import prbs_pkg::*;
#(
    parameter int          N    = PRBS_N,
    parameter logic [N-1:0] TAPS = PRBS_TAPS
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic use_pred,
    input  logic in_bit,
    output logic pred,
    output logic sr_zero
);

    logic [N-1:0] sr;
    logic         x;

    assign pred    = ^(sr & TAPS);
    assign x       = use_pred ? pred : in_bit;
    assign sr_zero = (sr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sr[N-2:0], x};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with lock detection, per-bit error
// strobe and saturating error count. Optional bit_cnt output: PRBS_CHK_BITCNT_EN.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int           N        = PRBS_N,
    parameter logic [N-1:0] TAPS     = PRBS_TAPS,
    parameter int           LOCK_CNT = PRBS_LOCK_CNT,
    parameter int           WIN      = PRBS_WIN,
    parameter int           LOSS_ERR = PRBS_LOSS_ERR,
    parameter int           ERR_W    = PRBS_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [ERR_W-1:0] bit_cnt
`endif
);

    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int EW = $clog2(LOSS_ERR + 1);

    localparam logic [FW-1:0] FILL_DONE = FW'(N);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN - 1);
    localparam logic [EW-1:0] LOSS_V    = EW'(LOSS_ERR);

    state_t           state, state_nxt;
    logic [FW-1:0]    fill, fill_nxt;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic [WW-1:0]    win_cnt, win_nxt;
    logic [EW-1:0]    win_err, win_err_nxt, win_err_inc;
    logic [ERR_W-1:0] err_cnt_nxt;
    logic             err_pulse_nxt;
    logic             pred, sr_zero, bit_err;

    prbs_chk_lfsr #(
        .N    (N),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (in_valid),
        .use_pred (state == LOCKED),
        .in_bit   (in_bit),
        .pred     (pred),
        .sr_zero  (sr_zero)
    );

    assign bit_err     = (in_bit != pred);
    assign win_err_inc = win_err + EW'(bit_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            fill      <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill      <= fill_nxt;
            match_cnt <= match_nxt;
            win_cnt   <= win_nxt;
            win_err   <= win_err_nxt;
            err_cnt   <= err_cnt_nxt;
            err_pulse <= err_pulse_nxt;
            locked    <= (state_nxt == LOCKED);
        end
    end

    always_comb begin
        state_nxt     = state;
        fill_nxt      = fill;
        match_nxt     = match_cnt;
        win_nxt       = win_cnt;
        win_err_nxt   = win_err;
        err_cnt_nxt   = err_cnt;
        err_pulse_nxt = 1'b0;

        case (state)
            HUNT: begin
                if (in_valid) begin
                    if (fill != FILL_DONE) begin
                        fill_nxt = fill + 1'b1;
                    end else if (sr_zero || bit_err) begin
                        // An all-zero register predicts zeros forever, so it never earns matches.
                        match_nxt = '0;
                    end else if (match_cnt == LOCK_LAST) begin
                        state_nxt   = LOCKED;
                        match_nxt   = '0;
                        win_nxt     = '0;
                        win_err_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (in_valid) begin
                    err_pulse_nxt = bit_err;
                    if (bit_err && (err_cnt != '1)) begin
                        err_cnt_nxt = err_cnt + 1'b1;
                    end
                    // Loss is judged before the window wraps so a last-bit error still counts.
                    if (win_err_inc == LOSS_V) begin
                        state_nxt   = HUNT;
                        fill_nxt    = '0;
                        match_nxt   = '0;
                        win_nxt     = '0;
                        win_err_nxt = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_nxt     = '0;
                        win_err_nxt = '0;
                    end else begin
                        win_nxt     = win_cnt + 1'b1;
                        win_err_nxt = win_err_inc;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase

        if (clear) begin
            err_cnt_nxt = '0;
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bit_cnt <= '0;
        end else if (in_valid && (state == LOCKED) && (bit_cnt != '1)) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end
`endif

endmodule
